p405s_dtlb_dsrefillctl: RTL and testbench
=========================================

# p405s_dtlb_dsRefillCtl

Refill and invalidate sequencer for the data-side shadow TLB words. Detects a data-side lookup that hits no shadow word, requests the translation from the unified TLB, and selects a victim word. It then drives that word's load strobes (`WordSel_N`, `rdNotWrt`) for one cycle, tracks per-word valid state, and broadcasts `invalidate` on context-synchronising events. It sits between the shadow word array, the UTLB port and the data-side pipeline hold logic.

## Interface
- `NUM_WORDS`, 4, number of shadow words controlled; legal range 2..8.
- `IDX_W`, 2, victim index width; equals ceil(log2(`NUM_WORDS`)).

- `CB`  in  1  clock; all state updates on rising edge.
- `Reset_N`  in  1  asynchronous, active-low reset.
- `dsLookupVal`  in  1  data-side translated access presented to the shadow words this cycle.
- `wordHit`  in  `NUM_WORDS`  per-word `Hit` from the shadow words.
- `invalidateReq`  in  1  context sync / tlbia / tlbwe request; invalidates all words.
- `utlbAck`  in  1  UTLB translation returned; RPN/attributes are valid on the shared bus this cycle.
- `utlbFault`  in  1  UTLB miss or protection fault for the requested EA.
- `utlbReq`  out  1  translation request to the UTLB.
- `dsHold`  out  1  hold data-side pipeline.
- `WordSel_N`  out  `NUM_WORDS`  active-low one-hot word load select.
- `rdNotWrt`  out  1  0 only during a load cycle.
- `invalidate`  out  1  broadcast invalidate to all words.
- `dsFault`  out  1  one-cycle pulse; translation fault reported to the pipeline.
- `multiHit`  out  1  one-cycle pulse; more than one `wordHit` set.
- `victimIdx`  out  `IDX_W`  index of the word to be or being loaded.

## Operation
- States: IDLE, REQ, LOAD, RETRY, INVAL.
- Internal state: `valid[NUM_WORDS]`, round-robin pointer `rr[IDX_W]`, latched `victim[IDX_W]`.
- Miss definition: `dsLookupVal & ~|wordHit`, sampled only in IDLE.
- IDLE:
  - On a miss, latch `victim` and go to REQ.
  - Victim selection: the lowest-index word with `valid=0`; otherwise `rr`.
- REQ:
  - `utlbReq=1`, `dsHold=1`.
  - `utlbAck` → LOAD.
  - `utlbFault` → IDLE, with `dsFault` pulsed in the next cycle.
  - If `utlbAck` and `utlbFault` arrive together, the fault wins.
- LOAD (exactly 1 cycle):
  - `WordSel_N[victim]=0`, all other bits 1; `rdNotWrt=0`; `dsHold=1`.
  - At the clock edge: `valid[victim]<=1`. If `victim==rr`, `rr<=(rr+1) mod NUM_WORDS`.
  - Next state: RETRY.
- RETRY (1 cycle): `dsHold=1`, `WordSel_N` all 1; the word array settles and the pipeline replays the lookup. Next state: IDLE.
- INVAL (1 cycle): `invalidate=1`, `dsHold=1`, `WordSel_N` all 1; all `valid<=0`, `rr<=0`. Next state: IDLE.
- `invalidateReq` has highest priority in every state and forces INVAL next cycle:
  - From REQ: `utlbReq` drops and the outstanding ack is discarded.
  - From LOAD: the load completes this cycle, then is invalidated.
- `utlbAck` or `utlbFault` outside REQ is ignored.
- `multiHit`: registered pulse, asserted the cycle after `dsLookupVal` with two or more `wordHit` set, in any state. No state change.
- `victimIdx`:
  - IDLE: the combinational candidate.
  - Other states: the latched `victim`.
- `rr` wraps `NUM_WORDS-1` → 0. For non-power-of-2 `NUM_WORDS`, `rr` never takes values ≥ `NUM_WORDS`.

## Timing
- Reset values (async assert, sync release):
  - state IDLE; `valid`=0; `rr`=0.
  - `utlbReq`=0, `dsHold`=0, `WordSel_N`=all 1, `rdNotWrt`=1, `invalidate`=0, `dsFault`=0, `multiHit`=0, `victimIdx`=0.
- All outputs are decoded from registered state (Moore) except `victimIdx` in IDLE.
- Miss in cycle T:
  - `utlbReq`/`dsHold` high from T+1.
  - With ack in T+1: LOAD in T+2, RETRY in T+3, IDLE (replayed lookup) in T+4.
  - Each ack wait cycle adds one cycle.
- Fault in REQ cycle F: `dsFault`=1 and state IDLE in F+1; `dsHold` low in F+1.
- `invalidateReq` in cycle I: `invalidate`=1 in I+1; IDLE in I+2.
- `Reset_N` asserted mid-REQ: `utlbReq` drops immediately (asynchronously), and no load occurs.

## Test plan
- Reset with `Reset_N`=0, then release → all outputs at reset values; the first miss selects `victimIdx`=0.
- Four misses, ack each after 1 wait cycle → words 0,1,2,3 loaded in order; `WordSel_N` goes 1110, 1101, 1011, 0111 (bit 0 rightmost), one cycle each. Fifth miss → victim=`rr`=0, and after that load `rr`=1.
- All words valid, miss, `utlbFault` in the second REQ cycle → no `WordSel_N` low; `dsFault` pulse of 1 cycle; `valid` unchanged.
- `invalidateReq` in the same cycle as `utlbAck` in REQ → next cycle INVAL with `invalidate`=1, no load; afterwards `valid`=0 and the next miss selects word 0.
- `utlbAck` and `utlbFault` asserted together → fault path taken; no load.
- `dsLookupVal` with `wordHit`=0011 → `multiHit` pulse next cycle; no REQ; no state change.

Source files
------------

// File: rtl/p405s_dtlb_dsrefillctl.sv
// Data-side shadow TLB refill / invalidate sequencer.
// A data-side lookup that hits no shadow word is a miss. On a miss the
// sequencer requests a translation from the UTLB, picks a victim word and
// strobes that word for one load cycle. It keeps a valid bit per word and
// broadcasts invalidate on context-synchronising requests. All outputs come
// from registers, except victimIdx while idle, which shows the live candidate.
module p405s_dtlb_dsrefillctl #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 CB,
  input  logic                 Reset_N,
  input  logic                 dsLookupVal,
  input  logic [NUM_WORDS-1:0] wordHit,
  input  logic                 invalidateReq,
  input  logic                 utlbAck,
  input  logic                 utlbFault,
  output logic                 utlbReq,
  output logic                 dsHold,
  output logic [NUM_WORDS-1:0] WordSel_N,
  output logic                 rdNotWrt,
  output logic                 invalidate,
  output logic                 dsFault,
  output logic                 multiHit,
  output logic [IDX_W-1:0]     victimIdx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_RETRY,
    S_INVAL
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_WORDS-1:0] valid;
  logic [IDX_W-1:0]     rr;
  logic [IDX_W-1:0]     rr_inc;
  logic [IDX_W-1:0]     victim;
  logic [IDX_W-1:0]     cand;
  logic                 miss;
  logic                 multi;

  // A lookup with no hit at all. It only matters while idle.
  assign miss  = dsLookupVal & ~|wordHit;
  // Two or more words claiming the same EA is an array consistency error.
  assign multi = dsLookupVal & ($countones(wordHit) > 1);

  // Round-robin pointer advance. It wraps explicitly, so the pointer never
  // reaches an unused index when NUM_WORDS is not a power of two.
  assign rr_inc = (rr == IDX_W'(NUM_WORDS - 1)) ? '0 : rr + 1'b1;

  // Victim candidate: the lowest-index empty word, or the round-robin word
  // when every word is valid.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it holding its old value (a latch).
    cand = rr;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (!valid[i]) cand = IDX_W'(i);
    end
  end

  // Next-state rules. An invalidate request overrides everything else. A
  // UTLB fault wins over a simultaneous ack.
  always_comb begin
    state_nxt = state;
    if (invalidateReq) begin
      state_nxt = S_INVAL;
    end else begin
      case (state)
        S_IDLE:  if (miss) state_nxt = S_REQ;
        S_REQ: begin
          if (utlbFault)    state_nxt = S_IDLE;
          else if (utlbAck) state_nxt = S_LOAD;
        end
        S_LOAD:  state_nxt = S_RETRY;
        S_RETRY: state_nxt = S_IDLE;
        S_INVAL: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, word bookkeeping, and registered outputs decoded from the next state.
  always_ff @(posedge CB or negedge Reset_N) begin
    if (!Reset_N) begin
      state      <= S_IDLE;
      valid      <= '0;
      rr         <= '0;
      victim     <= '0;
      utlbReq    <= 1'b0;
      dsHold     <= 1'b0;
      WordSel_N  <= '1;
      rdNotWrt   <= 1'b1;
      invalidate <= 1'b0;
      dsFault    <= 1'b0;
      multiHit   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only. Every
      // right-hand side then reads the value from before this edge, which
      // is what the hardware flops do.
      state <= state_nxt;

      case (state)
        // Freeze the victim when a miss is accepted. An invalidate in the
        // same cycle cancels the miss.
        S_IDLE: if (miss && !invalidateReq) victim <= cand;
        // The load always completes, even when an invalidate follows.
        S_LOAD: begin
          valid[victim] <= 1'b1;
          if (victim == rr) rr <= rr_inc;
        end
        S_INVAL: begin
          valid <= '0;
          rr    <= '0;
        end
        default: ;
      endcase

      utlbReq    <= (state_nxt == S_REQ);
      dsHold     <= (state_nxt != S_IDLE);
      rdNotWrt   <= (state_nxt != S_LOAD);
      invalidate <= (state_nxt == S_INVAL);
      WordSel_N  <= (state_nxt == S_LOAD) ? ~(NUM_WORDS'(1) << victim) : '1;
      dsFault    <= (state == S_REQ) && utlbFault && !invalidateReq;
      multiHit   <= multi;
    end
  end

  // While idle, show the word a miss would pick this cycle. Otherwise show
  // the word that was frozen for the refill in flight.
  assign victimIdx = (state == S_IDLE) ? cand : victim;

endmodule

// File: tb/tb_p405s_dtlb_dsrefillctl.sv
// Self-checking bench for the data-side shadow TLB refill sequencer.
// A transaction-level model predicts each cycle's outputs from the
// behavioural rules. The bench runs directed scenarios, then random traffic.
module tb_p405s_dtlb_dsrefillctl;

  localparam int N  = 4;
  localparam int IW = 2;

  // Model phases of a refill transaction
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RETRY = 3;
  localparam int M_INVAL = 4;

  logic          CB = 1'b0;
  logic          Reset_N;
  logic          dsLookupVal;
  logic [N-1:0]  wordHit;
  logic          invalidateReq;
  logic          utlbAck;
  logic          utlbFault;
  logic          utlbReq;
  logic          dsHold;
  logic [N-1:0]  WordSel_N;
  logic          rdNotWrt;
  logic          invalidate;
  logic          dsFault;
  logic          multiHit;
  logic [IW-1:0] victimIdx;

  always #5 CB = ~CB;

  p405s_dtlb_dsrefillctl #(.NUM_WORDS(N), .IDX_W(IW)) dut (
    .CB            (CB),
    .Reset_N       (Reset_N),
    .dsLookupVal   (dsLookupVal),
    .wordHit       (wordHit),
    .invalidateReq (invalidateReq),
    .utlbAck       (utlbAck),
    .utlbFault     (utlbFault),
    .utlbReq       (utlbReq),
    .dsHold        (dsHold),
    .WordSel_N     (WordSel_N),
    .rdNotWrt      (rdNotWrt),
    .invalidate    (invalidate),
    .dsFault       (dsFault),
    .multiHit      (multiHit),
    .victimIdx     (victimIdx)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     m_mode;
  int     m_rr;
  int     m_victim;
  bit     m_valid [N];
  bit     m_fault;
  bit     m_multi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_rr     = 0;
    m_victim = 0;
    m_fault  = 0;
    m_multi  = 0;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endtask

  // A miss takes the lowest empty word; with every word full it takes rr.
  function automatic int pick_victim();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return m_rr;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] sel;
    sel = '1;
    if (m_mode == M_LOAD) sel[m_victim] = 1'b0;
    check("utlbReq",    32'(utlbReq),    32'(m_mode == M_REQ));
    check("dsHold",     32'(dsHold),     32'(m_mode != M_IDLE));
    check("WordSel_N",  32'(WordSel_N),  32'(sel));
    check("rdNotWrt",   32'(rdNotWrt),   32'(m_mode != M_LOAD));
    check("invalidate", 32'(invalidate), 32'(m_mode == M_INVAL));
    check("dsFault",    32'(dsFault),    32'(m_fault));
    check("multiHit",   32'(multiHit),   32'(m_multi));
    check("victimIdx",  32'(victimIdx),  32'((m_mode == M_IDLE) ? pick_victim() : m_victim));
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_advance();
    int hits;
    bit inv;
    hits = 0;
    for (int i = 0; i < N; i++) hits += int'(wordHit[i]);
    inv     = invalidateReq;
    m_multi = dsLookupVal && (hits >= 2);
    m_fault = 0;
    case (m_mode)
      M_IDLE: begin
        if (inv) m_mode = M_INVAL;
        else if (dsLookupVal && hits == 0) begin
          m_victim = pick_victim();
          m_mode   = M_REQ;
        end
      end
      M_REQ: begin
        if (inv) m_mode = M_INVAL;
        else if (utlbFault) begin
          m_fault = 1;
          m_mode  = M_IDLE;
        end else if (utlbAck) m_mode = M_LOAD;
      end
      M_LOAD: begin
        m_valid[m_victim] = 1;
        if (m_victim == m_rr) m_rr = (m_rr + 1) % N;
        m_mode = inv ? M_INVAL : M_RETRY;
      end
      M_RETRY: m_mode = inv ? M_INVAL : M_IDLE;
      default: begin
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_rr   = 0;
        m_mode = inv ? M_INVAL : M_IDLE;
      end
    endcase
  endtask

  task automatic drive(input bit lv, input logic [N-1:0] hit, input bit inv,
                       input bit ack, input bit flt);
    dsLookupVal   = lv;
    wordHit       = hit;
    invalidateReq = inv;
    utlbAck       = ack;
    utlbFault     = flt;
  endtask

  // One clock: check the outputs mid-cycle, then step the model at the edge.
  task automatic step();
    @(negedge CB);
    check_outputs();
    @(posedge CB);
    model_advance();
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_sel;
    logic [N-1:0] hit;

    drive(0, '0, 0, 0, 0);
    Reset_N = 1'b0;
    model_reset();
    #12;
    check_outputs();
    check("reset_victim", 32'(victimIdx), 32'd0);
    @(posedge CB);
    #1;
    Reset_N = 1'b1;

    // Fill words 0..3 in order, then the fifth miss reuses rr=0.
    for (int w = 0; w < 5; w++) begin
      drive(1, '0, 0, 0, 0); step();
      drive(0, '0, 0, 0, 0); step();
      drive(0, '0, 0, 1, 0); step();
      exp_sel = '1;
      exp_sel[w % N] = 1'b0;
      check("load_sel", 32'(WordSel_N), 32'(exp_sel));
      drive(0, '0, 0, 0, 0); step();
      step();
      hit = '0;
      hit[w % N] = 1'b1;
      drive(1, hit, 0, 0, 0); step();
    end
    check("rr_after_wrap", 32'(victimIdx), 32'd1);

    // All words valid; the fault arrives in the second REQ cycle.
    drive(1, '0, 0, 0, 0); step();
    drive(0, '0, 0, 0, 0); step();
    drive(0, '0, 0, 0, 1); step();
    check("fault_pulse", 32'(dsFault), 32'd1);
    check("fault_nohold", 32'(dsHold), 32'd0);
    drive(0, '0, 0, 0, 0); step();
    check("fault_once", 32'(dsFault), 32'd0);

    // An invalidate with the ack discards the ack and clears all words.
    drive(1, '0, 0, 0, 0); step();
    drive(0, '0, 1, 1, 0); step();
    check("inval_flag", 32'(invalidate), 32'd1);
    check("inval_noload", 32'(WordSel_N), 32'hF);
    drive(0, '0, 0, 0, 0); step();
    check("inval_victim0", 32'(victimIdx), 32'd0);

    // A simultaneous ack and fault: the fault wins and no load happens.
    drive(1, '0, 0, 0, 0); step();
    drive(0, '0, 0, 1, 1); step();
    check("ackflt_fault", 32'(dsFault), 32'd1);
    check("ackflt_noload", 32'(WordSel_N), 32'hF);
    drive(0, '0, 0, 0, 0); step();
    check("ackflt_victim", 32'(victimIdx), 32'd0);

    // Two hits raise multiHit and do not start a refill.
    drive(1, 4'b0011, 0, 0, 0); step();
    check("multihit", 32'(multiHit), 32'd1);
    check("multihit_noreq", 32'(utlbReq), 32'd0);
    drive(0, '0, 0, 0, 0); step();

    // A reset during REQ drops utlbReq at once, and no load occurs.
    drive(1, '0, 0, 0, 0); step();
    drive(0, '0, 0, 1, 0);
    Reset_N = 1'b0;
    #1;
    check("async_reset_req", 32'(utlbReq), 32'd0);
    model_reset();
    @(posedge CB);
    #1;
    Reset_N = 1'b1;
    drive(0, '0, 0, 0, 0); step();
    check("reset_noload", 32'(victimIdx), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      hit = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      drive(($urandom_range(0, 1) == 1), hit, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
